// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: field-bundle input and encoded-word output handshakes of the RV32I encoder
interface instruction_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic        out_err;
  modport master (
    output in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, instruction, out_err
  );
  modport slave (
    input  in_valid, opcode, funct3, funct7, rd, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, instruction, out_err
  );
endinterface

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs RV32I fields into a word and queues it in a DEPTH-entry FIFO.
// Define ENC_RANGE_CHECK_EN to also flag immediates that do not fit their format.
module instruction_encoder #(
  parameter int DEPTH      = 2,
  parameter int NOP_ON_ERR = 1
) (
  input logic clk,
  input logic rst,
  instruction_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          rdy_q, rdy_d;
  logic [32:0]   mem_q [DEPTH];
  logic [32:0]   mem_d [DEPTH];
  logic [31:0]   word, imm;
  logic [6:0]    op;
  logic          bad, rerr, err, is_shift, push, pop;
  assign op       = bus.opcode;
  assign imm      = bus.imm;
  assign is_shift = op == 7'b0010011 && bus.funct3[1:0] == 2'b01;
  always_comb begin
    word = 32'h0;
    bad  = 1'b0;
    case (op)
      7'b0110011: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, op};
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011:
        word = is_shift ? {bus.funct7, imm[4:0], bus.rs1, bus.funct3, bus.rd, op}
                        : {imm[11:0], bus.rs1, bus.funct3, bus.rd, op};
      7'b0100011: word = {imm[11:5], bus.rs2, bus.rs1, bus.funct3, imm[4:0], op};
      7'b1100011: word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3, imm[4:1], imm[11], op};
      7'b0110111, 7'b0010111: word = {imm[31:12], bus.rd, op};
      7'b1101111: word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, op};
      default: bad = 1'b1;
    endcase
  end
`ifdef ENC_RANGE_CHECK_EN
  logic bad12, bad13, bad21;
  // A value fits N signed bits when every bit from N-1 upward equals the sign
  assign bad12 = !(&imm[31:11] || ~|imm[31:11]);
  assign bad13 = !(&imm[31:12] || ~|imm[31:12]);
  assign bad21 = !(&imm[31:20] || ~|imm[31:20]);
  always_comb begin
    rerr = 1'b0;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: rerr = is_shift ? |imm[31:5] : bad12;
      7'b0100011: rerr = bad12;
      7'b1100011: rerr = bad13 | imm[0];
      7'b0110111, 7'b0010111: rerr = |imm[11:0];
      7'b1101111: rerr = bad21 | imm[0];
      default: rerr = 1'b0;
    endcase
  end
`else
  assign rerr = 1'b0;
`endif
  assign err           = bad | rerr;
  assign bus.in_ready  = rdy_q && cnt_q != FULL;
  assign bus.out_valid = cnt_q != '0;
  assign bus.instruction = mem_q[rd_q][31:0];
  assign bus.out_err     = mem_q[rd_q][32];
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {err, (err && NOP_ON_ERR != 0) ? 32'h0000_0013 : word};
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    rdy_d = 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: directed and random checks of the encoder against an arithmetic reference model
module tb_instruction_encoder;
  localparam int DEPTH = 2;
`ifdef ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  logic [32:0] q [$];
  bit acc;
  instruction_encoder_if bus ();
  instruction_encoder #(.DEPTH(DEPTH), .NOP_ON_ERR(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [32:0] model(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, bit [4:0] rd,
                                        bit [4:0] rs1, bit [4:0] rs2, bit [31:0] imm);
    bit [31:0] w, base;
    bit bad, rerr;
    int si;
    si   = int'(imm);
    base = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    w = 0; bad = 0; rerr = 0;
    if (op == 7'h33) w = (32'(f7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
    else if (op == 7'h13 && (f3 == 1 || f3 == 5)) begin
      w = (32'(f7) << 25) | ((imm & 31) << 20) | base | (32'(rd) << 7);
      rerr = imm > 31;
    end else if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73) begin
      w = ((imm & 32'hFFF) << 20) | base | (32'(rd) << 7);
      rerr = si < -2048 || si > 2047;
    end else if (op == 7'h23) begin
      w = (((imm >> 5) & 127) << 25) | (32'(rs2) << 20) | base | ((imm & 31) << 7);
      rerr = si < -2048 || si > 2047;
    end else if (op == 7'h63) begin
      w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (32'(rs2) << 20) | base
        | (((imm >> 1) & 15) << 8) | (((imm >> 11) & 1) << 7);
      rerr = si < -4096 || si > 4095 || imm[0];
    end else if (op == 7'h37 || op == 7'h17) begin
      w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(op);
      rerr = (imm & 32'hFFF) != 0;
    end else if (op == 7'h6F) begin
      w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21) | (((imm >> 11) & 1) << 20)
        | (((imm >> 12) & 255) << 12) | (32'(rd) << 7) | 32'(op);
      rerr = si < -(1 << 20) || si >= (1 << 20) || imm[0];
    end else bad = 1;
    bad = bad || (RC && rerr);
    return {bad, bad ? 32'h13 : w};
  endfunction
  task automatic chk(string tag, logic [32:0] obs, logic [32:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, bit [4:0] rd, bit [4:0] rs1,
                       bit [4:0] rs2, bit [31:0] imm);
    bus.in_valid = 1; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2; bus.imm = imm;
  endtask
  task automatic drive_rand();
    bit [6:0] ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                           7'h13, 7'h7F, 7'h00};
    bit [31:0] imm;
    case ($urandom_range(0, 3))
      0: imm = $urandom;
      1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2: imm = $urandom_range(0, 40);
      default: imm = 32'($urandom_range(0, 8191)) << 1;
    endcase
    drive(ops[$urandom_range(0, 12)], 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), imm);
  endtask
  // Scoreboard step: compare handshake flags and head word, then advance one clock
  task automatic tick();
    logic [32:0] e;
    @(negedge clk);
    chk("in_ready", {32'h0, bus.in_ready}, {32'h0, q.size() < DEPTH});
    chk("out_valid", {32'h0, bus.out_valid}, {32'h0, q.size() != 0});
    acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) begin
      e = (q.size() != 0) ? q.pop_front() : 33'h0;
      chk("head", {bus.out_err, bus.instruction}, e);
    end
    if (acc) q.push_back(model(bus.opcode, bus.funct3, bus.funct7, bus.rd, bus.rs1, bus.rs2, bus.imm));
    @(posedge clk);
    #1;
  endtask
  task automatic single(bit [6:0] op, bit [2:0] f3, bit [6:0] f7, bit [4:0] rd, bit [4:0] rs1,
                        bit [4:0] rs2, bit [31:0] imm, logic [32:0] exp, string tag);
    bus.out_ready = 0;
    drive(op, f3, f7, rd, rs1, rs2, imm);
    tick();
    bus.in_valid = 0;
    chk({tag, "_acc"}, {32'h0, acc}, 33'h1);
    chk({tag, "_valid"}, {32'h0, bus.out_valid}, 33'h1);
    chk(tag, {bus.out_err, bus.instruction}, exp);
    bus.out_ready = 1;
    tick();
  endtask
  initial begin
    rst = 1;
    bus.in_valid = 0; bus.out_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 0;
    @(posedge clk);
    #1;
    chk("rst_ready", {32'h0, bus.in_ready}, 33'h0);
    chk("rst_valid", {32'h0, bus.out_valid}, 33'h0);
    chk("rst_word", {bus.out_err, bus.instruction}, 33'h0);
    rst = 0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", {32'h0, bus.in_ready}, 33'h1);
    single(7'h33, 0, 0, 3, 1, 2, 0, {1'b0, 32'h002081B3}, "r_type");
    single(7'h13, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, {1'b0, 32'hFFF00093}, "i_type");
    single(7'h63, 0, 0, 0, 1, 2, 8, {1'b0, 32'h00208463}, "b_type");
    single(7'h6F, 0, 0, 1, 0, 0, 32'h800, {1'b0, 32'h001000EF}, "j_type");
    single(7'h7F, 0, 0, 1, 2, 3, 0, {1'b1, 32'h00000013}, "bad_op");
    single(7'h13, 0, 0, 0, 0, 0, 4096, {RC, 32'h00000013}, "imm_range");
    // Backpressure: third push must be held off until the consumer drains
    bus.out_ready = 0;
    drive(7'h33, 0, 7'h20, 5, 6, 7, 0); tick();
    drive(7'h23, 2, 0, 0, 8, 9, 32'h7F0); tick();
    chk("full_ready", {32'h0, bus.in_ready}, 33'h0);
    drive(7'h37, 0, 0, 10, 0, 0, 32'hABCDE000);
    tick(); tick();
    chk("c_held", {32'h0, acc}, 33'h0);
    bus.out_ready = 1;
    for (int i = 0; i < 6 && !acc; i++) tick();
    chk("c_accepted", {32'h0, acc}, 33'h1);
    bus.in_valid = 0;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("bp_drained", {32'h0, q.size() == 0}, 33'h1);
    // Asynchronous reset with two entries queued
    bus.out_ready = 0;
    drive_rand(); tick();
    drive_rand(); tick();
    bus.in_valid = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", {32'h0, bus.out_valid}, 33'h0);
    chk("mid_rst_ready", {32'h0, bus.in_ready}, 33'h0);
    chk("mid_rst_word", {bus.out_err, bus.instruction}, 33'h0);
    q.delete();
    @(posedge clk);
    #2 rst = 0;
    @(posedge clk);
    #1;
    chk("rel_ready", {32'h0, bus.in_ready}, 33'h1);
    chk("rel_valid", {32'h0, bus.out_valid}, 33'h0);
    // Sustained stream: one word per cycle, occupancy stays at one
    bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      drive_rand();
      tick();
      chk("stream_acc", {32'h0, acc}, 33'h1);
      chk("stream_count", {32'h0, q.size() == 1}, 33'h1);
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive_rand(); else bus.in_valid = 0;
      bus.out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 10 && q.size() != 0; i++) tick();
    chk("final_drain", {32'h0, q.size() == 0}, 33'h1);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
